// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared encodings and constants for the unified memory arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        RESP_NONE  = 2'd0,
        RESP_FETCH = 2'd1,
        RESP_DATA  = 2'd2
    } resp_owner_e;

    localparam int DEFAULT_MAX_DATA_STREAK = 4;

    // Wide enough for the full 1..15 streak range.
    localparam int STREAK_W = 4;

    function automatic int be_width(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/mem_arb_prio.sv
// rtl/mem_arb_prio.sv - data-over-fetch priority select with fetch starvation streak counter
module mem_arb_prio
    import mem_arb_pkg::*;
#(
    parameter int MAX_DATA_STREAK = DEFAULT_MAX_DATA_STREAK
) (
    input  logic clk,
    input  logic rst,
    input  logic fetch_req,
    input  logic data_req,
    output logic fetch_win,
    output logic data_win,
    output logic forced_fetch
);

    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

    logic [STREAK_W-1:0] streak_cnt;
    logic                at_max;

    assign at_max = (streak_cnt == STREAK_MAX);

    always_comb begin
        fetch_win    = 1'b0;
        data_win     = 1'b0;
        forced_fetch = 1'b0;
        if (!rst) begin
            if (data_req && fetch_req) begin
                if (at_max) begin
                    fetch_win    = 1'b1;
                    forced_fetch = 1'b1;
                end else begin
                    data_win = 1'b1;
                end
            end else if (data_req) begin
                data_win = 1'b1;
            end else if (fetch_req) begin
                fetch_win = 1'b1;
            end
        end
    end

    // Counts only cycles where fetch was actually waiting behind data.
    always_ff @(posedge clk) begin
        if (rst) begin
            streak_cnt <= '0;
        end else if (fetch_win || !fetch_req) begin
            streak_cnt <= '0;
        end else if (data_win && !at_max) begin
            streak_cnt <= streak_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/unified_mem_arbiter.sv
// rtl/unified_mem_arbiter.sv - fetch/data arbiter for the unified memory; UNIFIED_MEM_ARBITER_STATS_EN adds stat counters
module unified_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MAX_DATA_STREAK = DEFAULT_MAX_DATA_STREAK
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                fetch_req,
    input  logic [ADDR_W-1:0]   fetch_addr,
    output logic                fetch_gnt,
    output logic                fetch_rvalid,
    output logic [DATA_W-1:0]   fetch_rdata,
    input  logic                data_req,
    input  logic                data_we,
    input  logic [DATA_W/8-1:0] data_be,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [DATA_W-1:0]   data_wdata,
    output logic                data_gnt,
    output logic                data_rvalid,
    output logic [DATA_W-1:0]   data_rdata,
    output logic                mem_en,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic [31:0]         stat_fetch_wait,
    output logic [31:0]         stat_forced_fetch
);

    localparam int BE_W = be_width(DATA_W);

    resp_owner_e owner_q;
    resp_owner_e owner_d;
    logic        forced_fetch;

    mem_arb_prio #(
        .MAX_DATA_STREAK(MAX_DATA_STREAK)
    ) u_prio (
        .clk         (clk),
        .rst         (rst),
        .fetch_req   (fetch_req),
        .data_req    (data_req),
        .fetch_win   (fetch_gnt),
        .data_win    (data_gnt),
        .forced_fetch(forced_fetch)
    );

    assign mem_en    = fetch_gnt | data_gnt;
    assign mem_we    = data_gnt & data_we;
    assign mem_be    = fetch_gnt ? {BE_W{1'b1}} : data_be;
    assign mem_addr  = fetch_gnt ? fetch_addr : data_addr;
    assign mem_wdata = data_wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q <= RESP_NONE;
        end else begin
            owner_q <= owner_d;
        end
    end

    always_comb begin
        owner_d = RESP_NONE;
        if (fetch_gnt) begin
            owner_d = RESP_FETCH;
        end else if (data_gnt) begin
            owner_d = RESP_DATA;
        end
    end

    // Gating with rst drops the response of an access caught by reset.
    assign fetch_rvalid = (owner_q == RESP_FETCH) && !rst;
    assign data_rvalid  = (owner_q == RESP_DATA) && !rst;
    assign fetch_rdata  = mem_rdata;
    assign data_rdata   = mem_rdata;

`ifdef UNIFIED_MEM_ARBITER_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_fetch_wait   <= '0;
            stat_forced_fetch <= '0;
        end else begin
            if (fetch_req && !fetch_gnt) begin
                stat_fetch_wait <= stat_fetch_wait + 32'd1;
            end
            if (forced_fetch) begin
                stat_forced_fetch <= stat_forced_fetch + 32'd1;
            end
        end
    end
`else
    logic unused_forced_fetch;
    assign unused_forced_fetch = forced_fetch;
    assign stat_fetch_wait     = '0;
    assign stat_forced_fetch   = '0;
`endif

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb/tb_unified_mem_arbiter.sv - directed self-checking bench for unified_mem_arbiter
module tb_unified_mem_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_gnt;
    logic              fetch_rvalid;
    logic [DATA_W-1:0] fetch_rdata;
    logic              data_req;
    logic              data_we;
    logic [3:0]        data_be;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic              data_gnt;
    logic              data_rvalid;
    logic [DATA_W-1:0] data_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [3:0]        mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic [31:0]       stat_fetch_wait;
    logic [31:0]       stat_forced_fetch;

    int errors = 0;
    int checks = 0;
    logic [31:0] base_wait;
    logic [31:0] base_forced;

    always #5 clk = ~clk;

    unified_mem_arbiter #(
        .ADDR_W         (ADDR_W),
        .DATA_W         (DATA_W),
        .MAX_DATA_STREAK(4)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .fetch_req        (fetch_req),
        .fetch_addr       (fetch_addr),
        .fetch_gnt        (fetch_gnt),
        .fetch_rvalid     (fetch_rvalid),
        .fetch_rdata      (fetch_rdata),
        .data_req         (data_req),
        .data_we          (data_we),
        .data_be          (data_be),
        .data_addr        (data_addr),
        .data_wdata       (data_wdata),
        .data_gnt         (data_gnt),
        .data_rvalid      (data_rvalid),
        .data_rdata       (data_rdata),
        .mem_en           (mem_en),
        .mem_we           (mem_we),
        .mem_be           (mem_be),
        .mem_addr         (mem_addr),
        .mem_wdata        (mem_wdata),
        .mem_rdata        (mem_rdata),
        .stat_fetch_wait  (stat_fetch_wait),
        .stat_forced_fetch(stat_forced_fetch)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        fetch_req  = 1'b1;
        fetch_addr = 32'h0;
        data_req   = 1'b1;
        data_we    = 1'b0;
        data_be    = 4'h0;
        data_addr  = 32'h0;
        data_wdata = 32'h0;
        mem_rdata  = 32'h0;
        tick();
        tick();
        check("rst_fetch_gnt", fetch_gnt, 0);
        check("rst_data_gnt", data_gnt, 0);
        check("rst_mem_en", mem_en, 0);
        check("rst_fetch_rvalid", fetch_rvalid, 0);
        check("rst_data_rvalid", data_rvalid, 0);
        check("rst_stat_wait", stat_fetch_wait, 0);
        rst       = 1'b0;
        fetch_req = 1'b0;
        data_req  = 1'b0;
        #1;
        check("idle_mem_en", mem_en, 0);

        // Fetch only, three cycles at 0x100
        fetch_req  = 1'b1;
        fetch_addr = 32'h100;
        for (int i = 0; i < 3; i++) begin
            mem_rdata = 32'hA000_0000 + 32'(i);
            #1;
            check("s1_fetch_gnt", fetch_gnt, 1);
            check("s1_data_gnt", data_gnt, 0);
            check("s1_mem_addr", mem_addr, 32'h100);
            check("s1_mem_we", mem_we, 0);
            check("s1_mem_be", mem_be, 4'hF);
            check("s1_fetch_rvalid", fetch_rvalid, (i > 0) ? 1 : 0);
            if (i > 0) check("s1_fetch_rdata", fetch_rdata, 32'hA000_0000 + 32'(i));
            tick();
        end
        fetch_req = 1'b0;
        #1;
        check("s1_last_rvalid", fetch_rvalid, 1);
        check("s1_drop_mem_en", mem_en, 0);
        tick();
        check("s1_rvalid_off", fetch_rvalid, 0);

        // Both requesting for 6 cycles: data x4, forced fetch, data
        base_wait   = stat_fetch_wait;
        base_forced = stat_forced_fetch;
        fetch_req   = 1'b1;
        fetch_addr  = 32'h200;
        data_req    = 1'b1;
        data_we     = 1'b0;
        data_be     = 4'hF;
        data_addr   = 32'h3000;
        for (int c = 1; c <= 6; c++) begin
            #1;
            check($sformatf("s2_data_gnt_c%0d", c), data_gnt, (c != 5) ? 1 : 0);
            check($sformatf("s2_fetch_gnt_c%0d", c), fetch_gnt, (c == 5) ? 1 : 0);
            check($sformatf("s2_mem_addr_c%0d", c), mem_addr, (c == 5) ? 32'h200 : 32'h3000);
            if (c == 6) begin
                check("s2_fetch_rvalid_c6", fetch_rvalid, 1);
                check("s2_data_rvalid_c6", data_rvalid, 0);
`ifdef UNIFIED_MEM_ARBITER_STATS_EN
                check("s2_stat_wait", stat_fetch_wait - base_wait, 4);
                check("s2_stat_forced", stat_forced_fetch - base_forced, 1);
`else
                check("s2_stat_wait", stat_fetch_wait, 0);
                check("s2_stat_forced", stat_forced_fetch, 0);
`endif
            end
            tick();
        end
        fetch_req = 1'b0;
        data_req  = 1'b0;
        tick();
        tick();

        // Store
        data_req   = 1'b1;
        data_we    = 1'b1;
        data_be    = 4'b0011;
        data_addr  = 32'h2004;
        data_wdata = 32'hDEADBEEF;
        #1;
        check("s3_data_gnt", data_gnt, 1);
        check("s3_mem_we", mem_we, 1);
        check("s3_mem_be", mem_be, 4'b0011);
        check("s3_mem_addr", mem_addr, 32'h2004);
        check("s3_mem_wdata", mem_wdata, 32'hDEADBEEF);
        tick();
        data_req = 1'b0;
        data_we  = 1'b0;
        #1;
        check("s3_data_rvalid", data_rvalid, 1);
        check("s3_fetch_rvalid", fetch_rvalid, 0);
        check("s3_mem_en", mem_en, 0);
        tick();

        // Load then fetch on consecutive cycles
        data_req  = 1'b1;
        data_be   = 4'hF;
        data_addr = 32'h40;
        #1;
        check("s4_load_gnt", data_gnt, 1);
        check("s4_load_we", mem_we, 0);
        tick();
        data_req   = 1'b0;
        fetch_req  = 1'b1;
        fetch_addr = 32'h80;
        mem_rdata  = 32'h11111111;
        #1;
        check("s4_data_rvalid", data_rvalid, 1);
        check("s4_data_rdata", data_rdata, 32'h11111111);
        check("s4_fetch_gnt", fetch_gnt, 1);
        check("s4_mem_addr", mem_addr, 32'h80);
        tick();
        fetch_req = 1'b0;
        mem_rdata = 32'h22222222;
        #1;
        check("s4_fetch_rvalid", fetch_rvalid, 1);
        check("s4_fetch_rdata", fetch_rdata, 32'h22222222);
        check("s4_data_rvalid_off", data_rvalid, 0);
        tick();

        // Reset the cycle after a data grant
        data_req = 1'b1;
        #1;
        check("s5_data_gnt", data_gnt, 1);
        tick();
        rst       = 1'b1;
        fetch_req = 1'b1;
        #1;
        check("s5_rst_data_rvalid", data_rvalid, 0);
        check("s5_rst_data_gnt", data_gnt, 0);
        check("s5_rst_fetch_gnt", fetch_gnt, 0);
        check("s5_rst_mem_en", mem_en, 0);
        tick();
        rst = 1'b0;
        #1;
        check("s5_post_data_rvalid", data_rvalid, 0);
        // A cleared streak means four more data wins before fetch is forced
        for (int c = 1; c <= 5; c++) begin
            #1;
            check($sformatf("s5_data_gnt_c%0d", c), data_gnt, (c != 5) ? 1 : 0);
            check($sformatf("s5_fetch_gnt_c%0d", c), fetch_gnt, (c == 5) ? 1 : 0);
            tick();
        end
        fetch_req = 1'b0;
        data_req  = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
